apb_master_bridge: RTL and testbench

- APB initiator driving the peripheral bus toward the VIC and other APB responders; converts a simple valid/ready request from the CPU-side interconnect into one APB transfer (SETUP then ACCESS) and returns read data/status on a one-cycle response strobe.
- Decodes the request address into one of NUM_SLAVES select lines; undecoded addresses and hung transfers complete with an error, with no bus lock-up.

---
 rtl/apb_master_bridge_if.sv | 39 +++
 rtl/apb_master_bridge.sv | 129 ++++++++++++
 tb/tb_apb_master_bridge.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/apb_master_bridge_if.sv
// Bundles the CPU-side request/response handshake and the APB bus of the bridge.
// master: the bridge's own view. slave: the view of the environment around it,
// meaning the requesting interconnect plus the APB responders.
interface apb_master_bridge_if #(
   parameter int NUM_SLAVES = 4
);
   // Request channel. A transfer is accepted on a rising edge where
   // req_valid && req_ready. req_ready depends only on bridge state and never
   // on req_valid. The request fields matter only in the accepting cycle.
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [31:0]           req_addr;
   logic [31:0]           req_wdata;
   // Response strobe: rsp_valid is high for exactly one cycle per accepted request.
   logic                  rsp_valid;
   logic [31:0]           rsp_rdata;
   logic                  rsp_err;
   // APB bus
   logic [NUM_SLAVES-1:0] psel;
   logic                  penable;
   logic [31:0]           paddr;
   logic                  pwrite;
   logic [31:0]           pwdata;
   logic [31:0]           prdata;
   logic                  pready;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, prdata, pready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
             psel, penable, paddr, pwrite, pwdata
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, prdata, pready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
             psel, penable, paddr, pwrite, pwdata
   );
endinterface

// File: rtl/apb_master_bridge.sv
// APB initiator: turns one valid/ready request into a single SETUP+ACCESS
// transfer. It decodes the slave from an address bit field. Undecoded
// addresses and transfers whose wait states run too long complete with an
// error response.
module apb_master_bridge #(
   parameter int NUM_SLAVES     = 4,
   parameter int SEL_LO         = 12,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  pclk,
   input  logic                  presetn,
   apb_master_bridge_if.master   bus,
   output logic [1:0]            state_dbg
);

   typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, RESP = 2'd3} state_t;

   // The wait counter holds values 0..TIMEOUT_CYCLES-1. It is never narrower than 1 bit.
   localparam int            CW        = $clog2(TIMEOUT_CYCLES + 2);
   localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);

   state_t                  state_q, state_d;
   logic [3:0]              idx_q;
   logic [CW-1:0]           wait_q;
   logic [31:0]             paddr_q, pwdata_q, rdata_q;
   logic                    pwrite_q, err_q;
   logic [NUM_SLAVES-1:0]   psel_d;

   logic [3:0]              req_idx;
   logic                    idx_ok, accept;
   logic                    rsp_load, rsp_err_d, wait_inc;
   logic [31:0]             rsp_rdata_d;

   assign req_idx = bus.req_addr[SEL_LO+3:SEL_LO];
   assign idx_ok  = ({1'b0, req_idx} < 5'(NUM_SLAVES));
   assign accept  = bus.req_valid && (state_q == IDLE);

   // State register. Reset returns the bus to IDLE at once, even mid-transfer.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next state. The response contents are loaded on the cycle that moves into RESP.
   always_comb begin
      state_d     = state_q;
      rsp_load    = 1'b0;
      rsp_err_d   = 1'b0;
      rsp_rdata_d = '0;
      wait_inc    = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (idx_ok) begin
                  state_d = SETUP;
               end else begin
                  // An undecoded address never reaches the bus and answers with an error.
                  state_d   = RESP;
                  rsp_load  = 1'b1;
                  rsp_err_d = 1'b1;
               end
            end
         end
         SETUP: state_d = ACCESS;
         ACCESS: begin
            if (bus.pready) begin
               state_d     = RESP;
               rsp_load    = 1'b1;
               rsp_rdata_d = pwrite_q ? 32'h0 : bus.prdata;
            end else if ((TIMEOUT_CYCLES != 0) && (wait_q == WAIT_LAST)) begin
               // The slave has held pready low too long. Give up the bus rather than hang.
               state_d   = RESP;
               rsp_load  = 1'b1;
               rsp_err_d = 1'b1;
            end else begin
               wait_inc = 1'b1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Transfer context, response holding registers and the wait-state counter.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         paddr_q  <= '0;
         pwrite_q <= 1'b0;
         pwdata_q <= '0;
         idx_q    <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         wait_q   <= '0;
      end else begin
         if (accept) begin
            paddr_q  <= bus.req_addr;
            pwrite_q <= bus.req_write;
            pwdata_q <= bus.req_wdata;
            idx_q    <= req_idx;
         end
         if (rsp_load) begin
            rdata_q <= rsp_rdata_d;
            err_q   <= rsp_err_d;
         end
         if (state_q == RESP)  wait_q <= '0;
         else if (wait_inc)    wait_q <= wait_q + 1'b1;
      end
   end

   // One-hot select. It is driven only in SETUP/ACCESS, and idx_q is always in range there.
   always_comb begin
      psel_d = '0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         psel_d[i] = ((state_q == SETUP) || (state_q == ACCESS)) && (idx_q == 4'(i));
      end
   end

   assign bus.req_ready = (state_q == IDLE);
   assign bus.psel      = psel_d;
   assign bus.penable   = (state_q == ACCESS);
   assign bus.paddr     = paddr_q;
   assign bus.pwrite    = pwrite_q;
   assign bus.pwdata    = pwdata_q;
   assign bus.rsp_valid = (state_q == RESP);
   assign bus.rsp_rdata = (state_q == RESP) ? rdata_q : 32'h0;
   assign bus.rsp_err   = (state_q == RESP) && err_q;
   assign state_dbg     = state_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge. A table of single transfers is run
// against a wait-state-programmable responder. Back-to-back requests and a
// reset during ACCESS are exercised by hand-written sequences.
module tb_apb_master_bridge;

   logic       pclk;
   logic       presetn;
   logic [1:0] state_dbg;

   apb_master_bridge_if #(.NUM_SLAVES(4)) bus ();

   apb_master_bridge #(.NUM_SLAVES(4), .SEL_LO(12), .TIMEOUT_CYCLES(16)) dut (
      .pclk      (pclk),
      .presetn   (presetn),
      .bus       (bus.master),
      .state_dbg (state_dbg)
   );

   // clock / reset
   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   int checks   = 0;
   int failures = 0;
   logic [32:0] exp_q[$];

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] prdata;
      int          waits;      // pready low for this many ACCESS cycles (99 = never)
      logic [3:0]  exp_psel;
      logic        exp_err;
      logic [31:0] exp_rdata;
      int          exp_lat;    // edge of rsp_valid, accept edge counted as 1
      int          exp_access; // ACCESS cycles seen on the bus
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // driver + responder for one transfer; call at #1 after a rising edge, state IDLE
   task automatic do_xfer(input int n, input vec_t v);
      int access_n = 0, setup_n = 0, bad = 0, lat = 0;
      logic [3:0] psel_or = '0;
      logic [32:0] exp;
      exp_q.push_back({v.exp_err, v.exp_rdata});
      chk($sformatf("v%0d_ready_idle", n), 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b1;
      bus.req_write = v.wr;
      bus.req_addr  = v.addr;
      bus.req_wdata = v.wdata;
      bus.pready    = 1'b0;
      @(posedge pclk); #1;
      bus.req_valid = 1'b0;
      bus.req_addr  = 32'hFFFF_FFFF;
      bus.req_wdata = 32'h5A5A_5A5A;
      chk($sformatf("v%0d_paddr", n), bus.paddr, v.addr);
      chk($sformatf("v%0d_pwrite", n), 32'(bus.pwrite), 32'(v.wr));
      chk($sformatf("v%0d_pwdata", n), bus.pwdata, v.wdata);
      for (int cyc = 1; cyc <= 40; cyc++) begin
         if (bus.psel != 4'b0 && bus.penable)  access_n++;
         if (bus.psel != 4'b0 && !bus.penable) setup_n++;
         if ($countones(bus.psel) > 1)          bad++;
         if (bus.penable && bus.psel == 4'b0)   bad++;
         if (bus.paddr !== v.addr)              bad++;
         if (bus.req_ready)                     bad++;
         psel_or = psel_or | bus.psel;
         if (bus.rsp_valid) begin
            lat = cyc;
            break;
         end
         bus.pready = bus.penable && (access_n > v.waits);
         bus.prdata = bus.pready ? v.prdata : (32'hDEAD_0000 | 32'(cyc));
         @(posedge pclk); #1;
      end
      bus.pready = 1'b0;
      exp = exp_q.pop_front();
      chk($sformatf("v%0d_latency", n), 32'(lat), 32'(v.exp_lat));
      if (lat != 0) begin
         chk($sformatf("v%0d_rsp_err", n), 32'(bus.rsp_err), 32'(exp[32]));
         chk($sformatf("v%0d_rsp_rdata", n), bus.rsp_rdata, exp[31:0]);
      end
      chk($sformatf("v%0d_psel", n), 32'(psel_or), 32'(v.exp_psel));
      chk($sformatf("v%0d_setup_cycles", n), 32'(setup_n), (v.exp_psel != 4'b0) ? 32'd1 : 32'd0);
      chk($sformatf("v%0d_access_cycles", n), 32'(access_n), 32'(v.exp_access));
      chk($sformatf("v%0d_bus_rules", n), 32'(bad), 32'd0);
      @(posedge pclk); #1;
      chk($sformatf("v%0d_rsp_one_cycle", n), 32'(bus.rsp_valid), 32'd0);
      chk($sformatf("v%0d_rsp_rdata_idle", n), bus.rsp_rdata, 32'h0);
      chk($sformatf("v%0d_ready_after", n), 32'(bus.req_ready), 32'd1);
      chk($sformatf("v%0d_paddr_kept", n), bus.paddr, v.addr);
   endtask

   initial begin
      int rsp_seen;
      //             wr    addr           wdata          prdata        wt  psel     err   rdata        lat acc
      vecs[0] = '{1'b1, 32'h0000_1010, 32'hA5A5_0001, 32'hFFFF_FFFF, 0,  4'b0010, 1'b0, 32'h0,         3,  1};
      vecs[1] = '{1'b0, 32'h0000_0004, 32'h0,         32'h1234_5678, 3,  4'b0001, 1'b0, 32'h1234_5678, 6,  4};
      vecs[2] = '{1'b0, 32'h0000_7000, 32'h0,         32'h0,         0,  4'b0000, 1'b1, 32'h0,         1,  0};
      vecs[3] = '{1'b0, 32'h0000_3FFC, 32'h0,         32'hCAFE_F00D, 1,  4'b1000, 1'b0, 32'hCAFE_F00D, 4,  2};
      vecs[4] = '{1'b1, 32'h0000_2008, 32'h0BAD_BEEF, 32'h5555_5555, 2,  4'b0100, 1'b0, 32'h0,         5,  3};
      vecs[5] = '{1'b1, 32'h0000_4000, 32'h1111_1111, 32'h0,         0,  4'b0000, 1'b1, 32'h0,         1,  0};
      vecs[6] = '{1'b0, 32'hFFFF_2100, 32'h0,         32'h0000_0001, 0,  4'b0100, 1'b0, 32'h0000_0001, 3,  1};
      vecs[7] = '{1'b0, 32'h0001_F000, 32'h0,         32'h0,         0,  4'b0000, 1'b1, 32'h0,         1,  0};
      vecs[8] = '{1'b0, 32'h0000_1FFC, 32'h0,         32'h0000_BEEF, 99, 4'b0010, 1'b1, 32'h0,         18, 16};
      vecs[9] = '{1'b1, 32'h0000_0000, 32'h0000_0077, 32'h0,         0,  4'b0001, 1'b0, 32'h0,         3,  1};

      presetn       = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = 32'h0;
      bus.req_wdata = 32'h0;
      bus.prdata    = 32'h0;
      bus.pready    = 1'b0;
      #2;
      chk("rst_psel", 32'(bus.psel), 32'h0);
      chk("rst_penable", 32'(bus.penable), 32'h0);
      chk("rst_paddr", bus.paddr, 32'h0);
      chk("rst_pwrite", 32'(bus.pwrite), 32'h0);
      chk("rst_pwdata", bus.pwdata, 32'h0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
      chk("rst_rsp_err", 32'(bus.rsp_err), 32'h0);
      chk("rst_req_ready", 32'(bus.req_ready), 32'h1);
      repeat (2) @(posedge pclk);
      @(negedge pclk) presetn = 1'b1;
      @(posedge pclk); #1;
      chk("post_rst_ready", 32'(bus.req_ready), 32'h1);

      // table of single transfers
      for (int i = 0; i < 10; i++) do_xfer(i, vecs[i]);

      // back-to-back: req_valid held with a second request queued behind the first
      bus.pready    = 1'b1;
      bus.prdata    = 32'h0B0B_0B0B;
      bus.req_valid = 1'b1;
      bus.req_write = 1'b1;
      bus.req_addr  = 32'h0000_1000;
      bus.req_wdata = 32'h0000_000A;
      @(posedge pclk); #1;
      bus.req_write = 1'b0;
      bus.req_addr  = 32'h0000_2000;
      chk("b2b_ready_setup", 32'(bus.req_ready), 32'h0);
      chk("b2b_a_psel", 32'(bus.psel), 32'b0010);
      @(posedge pclk); #1;
      chk("b2b_ready_access", 32'(bus.req_ready), 32'h0);
      @(posedge pclk); #1;
      chk("b2b_ready_resp", 32'(bus.req_ready), 32'h0);
      chk("b2b_a_rsp_valid", 32'(bus.rsp_valid), 32'h1);
      chk("b2b_a_rsp_err", 32'(bus.rsp_err), 32'h0);
      chk("b2b_a_rsp_rdata", bus.rsp_rdata, 32'h0);
      @(posedge pclk); #1;
      chk("b2b_idle_ready", 32'(bus.req_ready), 32'h1);
      chk("b2b_idle_psel", 32'(bus.psel), 32'h0);
      chk("b2b_idle_paddr_kept", bus.paddr, 32'h0000_1000);
      @(posedge pclk); #1;
      bus.req_valid = 1'b0;
      chk("b2b_b_psel", 32'(bus.psel), 32'b0100);
      chk("b2b_b_penable", 32'(bus.penable), 32'h0);
      chk("b2b_b_paddr", bus.paddr, 32'h0000_2000);
      @(posedge pclk); #1;
      chk("b2b_b_access", 32'(bus.penable), 32'h1);
      @(posedge pclk); #1;
      chk("b2b_b_rsp_valid", 32'(bus.rsp_valid), 32'h1);
      chk("b2b_b_rsp_rdata", bus.rsp_rdata, 32'h0B0B_0B0B);
      bus.pready = 1'b0;
      @(posedge pclk); #1;

      // reset asserted while the transfer is in ACCESS
      bus.req_valid = 1'b1;
      bus.req_write = 1'b0;
      bus.req_addr  = 32'h0000_1000;
      @(posedge pclk); #1;
      bus.req_valid = 1'b0;
      @(posedge pclk); #1;
      chk("mid_rst_in_access", 32'(bus.penable), 32'h1);
      #2 presetn = 1'b0;
      #1;
      chk("mid_rst_psel", 32'(bus.psel), 32'h0);
      chk("mid_rst_penable", 32'(bus.penable), 32'h0);
      chk("mid_rst_paddr", bus.paddr, 32'h0);
      chk("mid_rst_ready", 32'(bus.req_ready), 32'h1);
      rsp_seen = 0;
      repeat (2) begin
         @(posedge pclk); #1;
         if (bus.rsp_valid) rsp_seen++;
      end
      @(negedge pclk) presetn = 1'b1;
      repeat (3) begin
         @(posedge pclk); #1;
         if (bus.rsp_valid) rsp_seen++;
      end
      chk("mid_rst_no_rsp", 32'(rsp_seen), 32'h0);
      chk("mid_rst_ready_after", 32'(bus.req_ready), 32'h1);
      do_xfer(10, vecs[0]);

      chk("exp_q_empty", 32'(exp_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
